press_classifier: RTL and testbench
===================================

Name: press_classifier

Overview:
- Sits directly downstream of the push-button debouncer.
- Consumes its single-cycle rise/fall pulses and turns each press into a classified event: short press, long press, or auto-repeat while held.
- Measures press duration in ms-scale ticks and exposes the last completed duration for the control logic / register map.

Parameters:
- CNT_WIDTH, 17, width of tick prescaler.
- TICK_DIV, 17'd100000, clk cycles per duration tick (1 ms at 100 MHz).
- DUR_WIDTH, 12, width of duration / window counters.
- LONG_TICKS, 12'd1000, hold duration (ticks) at which a press becomes long. Must be ≥ 1.
- REPEAT_TICKS, 12'd200, tick period of auto-repeat once long. 0 disables repeat.
- DOUBLE_TICKS, 12'd300, double-click window in ticks. Used only with the macro.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- press_rise  input  1  1-cycle pulse: button pressed (debounced).
- press_fall  input  1  1-cycle pulse: button released (debounced).
- pressed  output  1  level, high while the state machine considers the button held.
- short_press  output  1  1-cycle pulse.
- long_press  output  1  1-cycle pulse.
- repeat_press  output  1  1-cycle pulse.
- double_press  output  1  1-cycle pulse. Constant 0 without the macro.
- last_dur  output  DUR_WIDTH  duration (ticks) of the most recently released press.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset rst_n is asynchronous, active-low.
  - All outputs and internal state go to 0 / IDLE immediately on assertion, including mid-press. The press in progress is discarded with no event.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 and raises tick when the count equals TICK_DIV-1.
  - It is cleared to 0 on every accepted press_rise, so duration is quantised from press start.
- Duration counter dur:
  - Cleared on accepted rise.
  - Increments on tick in PRESSED/LONG.
  - Saturates at all-ones; no wrap-around.
- States: IDLE, PRESSED, LONG (plus WAIT2 with the macro).
- IDLE:
  - press_rise → PRESSED, dur=0, pressed=1.
  - press_fall is ignored.
- PRESSED:
  - On the tick where dur becomes LONG_TICKS → LONG. long_press=1 in the next cycle, for exactly one cycle.
  - press_fall → IDLE, last_dur<=dur, pressed=0. short_press=1 in the cycle after the fall.
  - press_rise is ignored.
- LONG:
  - Repeat counter is cleared on entry. It counts ticks, and when it reaches REPEAT_TICKS it pulses repeat_press (next cycle) and restarts.
  - press_fall → IDLE, last_dur<=dur, with no short/long pulse. A pending repeat on the same cycle is suppressed.
- Simultaneous press_rise and press_fall in one cycle: both are ignored, with no state change.
- At most one of the event outputs is high in any cycle.
- Registered outputs: every output is a flop. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: PRESS_CLASSIFIER_DOUBLE_CLICK_EN.
- Defined:
  - press_fall in PRESSED → WAIT2 (pressed=0, last_dur updated, window counter cleared). No short_press yet.
  - In WAIT2, window counts ticks.
  - press_rise before the window reaches DOUBLE_TICKS → double_press next cycle, then enter PRESSED with a suppress flag set. The release of that press emits no short_press. Long and repeat still apply.
  - Window reaching DOUBLE_TICKS → short_press next cycle, then IDLE.
  - Reset in WAIT2 drops the pending short.
- Undefined:
  - WAIT2 logic is absent and double_press is tied 0.
  - short_press occurs one cycle after release, as specified above.

Test Plan:
- Press of 50 ticks (TICK_DIV=10, LONG_TICKS=100): rise, fall 500 clks later → short_press one cycle after fall, last_dur=50, no long_press.
- Hold 350 ticks with REPEAT_TICKS=100 → long_press after tick 100, repeat_press after ticks 200 and 300, no short_press on release, last_dur=350.
- Hold past 4095 ticks with DUR_WIDTH=12 → last_dur=4095 (saturated). Stray press_fall in IDLE and press_rise in PRESSED produce no events.
- rst_n low at tick 60 of a press, fall later → no events, all outputs 0, last_dur=0.
- Same-cycle rise+fall in IDLE → state stays IDLE, no pulses, pressed stays 0.
- With PRESS_CLASSIFIER_DOUBLE_CLICK_EN and DOUBLE_TICKS=30:
  - Two 10-tick presses 20 ticks apart → single double_press, no short_press.
  - Gap of 40 ticks → short_press at window expiry, then a second short later.

Source files
------------

// File: rtl/press_classifier_if.sv
// Handshake bundle between the debouncer side (master) and press_classifier (slave):
// debounced rise/fall pulses in, classified events and last press duration out.
interface press_classifier_if #(
  parameter int DUR_WIDTH = 12
);
  logic                 press_rise;
  logic                 press_fall;
  logic                 pressed;
  logic                 short_press;
  logic                 long_press;
  logic                 repeat_press;
  logic                 double_press;
  logic [DUR_WIDTH-1:0] last_dur;

  modport master (
    output press_rise, press_fall,
    input  pressed, short_press, long_press, repeat_press, double_press, last_dur
  );

  modport slave (
    input  press_rise, press_fall,
    output pressed, short_press, long_press, repeat_press, double_press, last_dur
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced presses into short / long / auto-repeat events and reports the last
// press duration in prescaled ticks. Double-click detection: PRESS_CLASSIFIER_DOUBLE_CLICK_EN.
module press_classifier #(
  parameter int                   CNT_WIDTH    = 17,
  parameter logic [CNT_WIDTH-1:0] TICK_DIV     = 17'd100000,
  parameter int                   DUR_WIDTH    = 12,
  parameter logic [DUR_WIDTH-1:0] LONG_TICKS   = 12'd1000,
  parameter logic [DUR_WIDTH-1:0] REPEAT_TICKS = 12'd200,
  parameter logic [DUR_WIDTH-1:0] DOUBLE_TICKS = 12'd300
) (
  input  logic              clk,
  input  logic              rst_n,
  press_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
    , S_WAIT2 = 2'd3
`endif
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TICK_LAST = TICK_DIV - 1'b1;
  localparam logic [DUR_WIDTH-1:0] DUR_MAX   = '1;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_presc;
  logic [DUR_WIDTH-1:0] r_dur;
  logic [DUR_WIDTH-1:0] r_rep;
  logic [DUR_WIDTH-1:0] r_last_dur;
  logic                 r_pressed;
  logic                 r_short;
  logic                 r_long;
  logic                 r_repeat;
  logic                 r_double;

  logic                 w_tick;
  logic                 w_rise;
  logic                 w_fall;
  logic [DUR_WIDTH-1:0] w_dur_inc;
  logic [DUR_WIDTH-1:0] w_dur_now;
  logic [DUR_WIDTH-1:0] w_rep_inc;
  logic                 w_rep_wrap;
  logic                 w_start;
  logic                 w_capture;
  logic                 w_rep_clr;
  logic                 w_short_next;
  logic                 w_long_next;
  logic                 w_repeat_next;
  logic                 w_double_next;

`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
  logic [DUR_WIDTH-1:0] r_win;
  logic [DUR_WIDTH-1:0] w_win_inc;
  logic                 r_supp;
  logic                 w_win_clr;
  logic                 w_supp_set;
  logic                 w_supp_clr;

  assign w_win_inc = r_win + 1'b1;
`else
  logic w_unused_double;
  assign w_unused_double = ^DOUBLE_TICKS;
`endif

  // A rise and fall arriving together cancel out and are treated as no input.
  assign w_tick     = (r_presc == TICK_LAST);
  assign w_rise     = bus.press_rise & ~bus.press_fall;
  assign w_fall     = bus.press_fall & ~bus.press_rise;
  assign w_dur_inc  = (r_dur == DUR_MAX) ? r_dur : r_dur + 1'b1;
  assign w_dur_now  = w_tick ? w_dur_inc : r_dur;
  assign w_rep_inc  = r_rep + 1'b1;
  assign w_rep_wrap = w_tick && (REPEAT_TICKS != '0) && (w_rep_inc == REPEAT_TICKS);

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_capture     = 1'b0;
    w_rep_clr     = 1'b0;
    w_short_next  = 1'b0;
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    w_double_next = 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
    w_win_clr     = 1'b0;
    w_supp_set    = 1'b0;
    w_supp_clr    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_next = S_PRESSED;
          w_start      = 1'b1;
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
          w_supp_clr   = 1'b1;
`endif
        end
      end
      S_PRESSED: begin
        // Release wins over a long transition landing on the same tick.
        if (w_fall) begin
          w_capture = 1'b1;
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
          if (r_supp) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT2;
            w_win_clr    = 1'b1;
          end
`else
          w_state_next = S_IDLE;
          w_short_next = 1'b1;
`endif
        end else if (w_tick && (w_dur_inc == LONG_TICKS)) begin
          w_state_next = S_LONG;
          w_long_next  = 1'b1;
          w_rep_clr    = 1'b1;
        end
      end
      S_LONG: begin
        if (w_fall) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_rep_wrap) begin
          w_repeat_next = 1'b1;
        end
      end
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
      S_WAIT2: begin
        // A second press on the expiry tick still counts as a double click.
        if (w_rise) begin
          w_state_next  = S_PRESSED;
          w_start       = 1'b1;
          w_double_next = 1'b1;
          w_supp_set    = 1'b1;
        end else if (w_tick && (w_win_inc == DOUBLE_TICKS)) begin
          w_state_next = S_IDLE;
          w_short_next = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_dur      <= '0;
      r_rep      <= '0;
      r_last_dur <= '0;
      r_pressed  <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_double   <= 1'b0;
    end else begin
      // Prescaler restarts with each press so durations are quantised from press start.
      if (w_start || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_start) begin
        r_dur <= '0;
      end else if (w_tick && ((r_state == S_PRESSED) || (r_state == S_LONG))) begin
        r_dur <= w_dur_inc;
      end

      if (w_rep_clr) begin
        r_rep <= '0;
      end else if ((r_state == S_LONG) && w_tick) begin
        r_rep <= w_rep_wrap ? '0 : w_rep_inc;
      end

      // Captured duration includes a tick that coincides with the release cycle.
      if (w_capture) begin
        r_last_dur <= w_dur_now;
      end

      r_pressed <= (w_state_next == S_PRESSED) || (w_state_next == S_LONG);
      r_short   <= w_short_next;
      r_long    <= w_long_next;
      r_repeat  <= w_repeat_next;
      r_double  <= w_double_next;
    end
  end

`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= '0;
      r_supp <= 1'b0;
    end else begin
      if (w_win_clr) begin
        r_win <= '0;
      end else if ((r_state == S_WAIT2) && w_tick) begin
        r_win <= w_win_inc;
      end

      if (w_supp_set) begin
        r_supp <= 1'b1;
      end else if (w_supp_clr) begin
        r_supp <= 1'b0;
      end
    end
  end
`endif

  assign bus.pressed      = r_pressed;
  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.repeat_press = r_repeat;
  assign bus.double_press = r_double;
  assign bus.last_dur     = r_last_dur;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: random and directed presses, expected events derived
// from press start/release times in clock edges, compared by an independent monitor.
module tb_press_classifier;
  localparam int TD   = 10;
  localparam int LT   = 100;
  localparam int RT   = 100;
  localparam int WT   = 30;
  localparam int DMAX = 4095;

  typedef struct {
    int kind;
    int edge_n;
    int dur;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  bit m_held = 0;
  bit m_supp = 0;
  bit m_wait = 0;
  int m_start = 0;
  int m_wexp = 0;
  int m_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  press_classifier_if #(.DUR_WIDTH(12)) u_if();

  press_classifier #(
    .CNT_WIDTH(17), .TICK_DIV(17'd10), .DUR_WIDTH(12),
    .LONG_TICKS(12'd100), .REPEAT_TICKS(12'd100), .DOUBLE_TICKS(12'd30)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(u_if)
  );

  function automatic string kname(input int k);
    case (k)
      0: return "short";
      1: return "long";
      2: return "repeat";
      3: return "double";
      default: return "none";
    endcase
  endfunction

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at edge %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int e);
    ev_t ev;
    ev.kind = kind;
    ev.edge_n = e;
    ev.dur = m_last;
    exp_q.push_back(ev);
  endtask

  // Reference: events follow from the press start edge and the tick period alone.
  task automatic model_step(input bit rise, input bit fall, input int e);
    int rel;
    if (!m_held && !m_wait) begin
      if (rise && !fall) begin
        m_held = 1; m_start = e; m_supp = 0;
      end
    end else if (m_wait) begin
      if (rise && !fall) begin
        push(3, e);
        m_wait = 0; m_held = 1; m_start = e; m_supp = 1;
      end else if (e == m_wexp) begin
        push(0, e);
        m_wait = 0;
      end
    end else begin
      rel = e - m_start;
      if (fall && !rise) begin
        m_held = 0;
        m_last = (rel / TD > DMAX) ? DMAX : rel / TD;
        if (rel <= LT * TD && !m_supp) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
          m_wait = 1;
          m_wexp = m_start + TD * (rel / TD + WT);
`else
          push(0, e);
`endif
        end
      end else if (rel == LT * TD) begin
        push(1, e);
      end else if (RT != 0 && rel > LT * TD && ((rel - LT * TD) % (RT * TD)) == 0) begin
        push(2, e);
      end
    end
  endtask

  task automatic step(input bit rise, input bit fall);
    @(negedge clk);
    u_if.press_rise = rise;
    u_if.press_fall = fall;
    if (rst_n) model_step(rise, fall, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    u_if.press_rise = 1'b0;
    u_if.press_fall = 1'b0;
    m_held = 0; m_supp = 0; m_wait = 0; m_last = 0;
    exp_q.delete();
    #1;
    check_val("async_reset_outputs",
              int'({u_if.pressed, u_if.short_press, u_if.long_press, u_if.repeat_press,
                    u_if.double_press, u_if.last_dur}), 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: levels every cycle, pulses popped from the scoreboard as they appear.
  initial begin
    int n;
    int k;
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      check_val("pressed", int'(u_if.pressed), int'(m_held));
      check_val("last_dur", int'(u_if.last_dur), m_last);
      while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event %s required at edge %0d, not observed by edge %0d",
                 kname(ev.kind), ev.edge_n, cyc);
      end
      n = int'(u_if.short_press) + int'(u_if.long_press) + int'(u_if.repeat_press) +
          int'(u_if.double_press);
      k = u_if.short_press ? 0 : u_if.long_press ? 1 : u_if.repeat_press ? 2 : 3;
      if (n > 1) check_val("one_hot_events", n, 1);
      if (n >= 1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event %s at edge %0d, required none", kname(k), cyc);
        end else begin
          ev = exp_q.pop_front();
          checks++;
          if (ev.kind != k || ev.edge_n != cyc || ev.dur != int'(u_if.last_dur)) begin
            errors++;
            $display("FAIL event actual %s@%0d dur %0d required %s@%0d dur %0d",
                     kname(k), cyc, u_if.last_dur, kname(ev.kind), ev.edge_n, ev.dur);
          end
        end
      end
    end
  end

  initial begin
    int r;
    int len;
    u_if.press_rise = 1'b0;
    u_if.press_fall = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_state",
              int'({u_if.pressed, u_if.short_press, u_if.long_press, u_if.repeat_press,
                    u_if.double_press, u_if.last_dur}), 0);
    rst_n = 1'b1;
    idle(5);

    // 50-tick short press
    step(1'b1, 1'b0); idle(499); step(1'b0, 1'b1); idle(5);
    check_val("short_last_dur", int'(u_if.last_dur), 50);

    // 350-tick hold with long + two repeats
    step(1'b1, 1'b0); idle(3499); step(1'b0, 1'b1); idle(5);
    check_val("long_last_dur", int'(u_if.last_dur), 350);

    // Stray fall in IDLE, stray rise while held, saturating hold
    step(1'b0, 1'b1); idle(3);
    step(1'b1, 1'b0); idle(200); step(1'b1, 1'b0); idle(41000); step(1'b0, 1'b1); idle(5);
    check_val("saturated_last_dur", int'(u_if.last_dur), DMAX);

    // Reset at tick 60 of a press discards it
    step(1'b1, 1'b0); idle(604);
    do_reset(4);
    idle(20); step(1'b0, 1'b1); idle(5);
    check_val("reset_drop_last_dur", int'(u_if.last_dur), 0);

    // Simultaneous rise+fall in IDLE
    step(1'b1, 1'b1); idle(3);
    check_val("same_cycle_pressed", int'(u_if.pressed), 0);

    // Release exactly on the long boundary
    step(1'b1, 1'b0); idle(999); step(1'b0, 1'b1); idle(5);

`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
    idle(400);
    step(1'b1, 1'b0); idle(99); step(1'b0, 1'b1); idle(199);
    step(1'b1, 1'b0); idle(99); step(1'b0, 1'b1); idle(400);
    step(1'b1, 1'b0); idle(99); step(1'b0, 1'b1); idle(399);
    step(1'b1, 1'b0); idle(99); step(1'b0, 1'b1); idle(400);
`endif

    // Randomised presses with glitches
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 3) step(1'b0, 1'b1);
        else if (r == 3) step(1'b1, 1'b1);
        else step(1'b0, 1'b0);
      end
      step(1'b1, 1'b0);
      r = $urandom_range(0, 2);
      len = (r == 0) ? $urandom_range(1, 1200) :
            (r == 1) ? $urandom_range(980, 1020) : $urandom_range(1000, 2000);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r == 0) step(1'b1, 1'b0);
        else if (r == 1) step(1'b1, 1'b1);
        else step(1'b0, 1'b0);
      end
      step(1'b0, 1'b1);
    end
    idle(400);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
